// File: rtl/ddr_arb_pkg.sv
// Shared types and the round-robin pick helper for the DDR burst arbiter.
package ddr_arb_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [2:0] {IDLE, ARB, AW, WDATA, WRESP, AR, RDATA} arb_state_t;

  // First set bit of req at or after ptr, wrapping; unused upper bits of req must be zero,
  // which makes the mod-8 wrap equivalent to a mod-NUM_REQ wrap.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    rr_pick = ptr;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick plus the registered rotate pointer.
module rr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [IDX_W-1:0]   pick,
  output logic               any
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign any  = |req;
  assign pick = IDX_W'(rr_pick(MAX_REQ'(req), 3'(ptr_q)));

  always_comb begin
    ptr_d = ptr_q;
    if (update) begin
      ptr_d = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + IDX_W'(1);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Round-robin sharing of one AXI4 slave port among burst clients, one burst outstanding.
module ddr_burst_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  input  logic [NUM_REQ-1:0]            cl_wvalid,
  output logic [NUM_REQ-1:0]            cl_wready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] cl_wdata,
  output logic [NUM_REQ-1:0]            cl_rvalid,
  input  logic [NUM_REQ-1:0]            cl_rready,
  output logic [DATA_WIDTH-1:0]         cl_rdata,
  output logic                          cl_rlast,
  output logic [NUM_REQ-1:0]            cl_done,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [ADDR_WIDTH-1:0]         m_awaddr,
  output logic [LEN_WIDTH-1:0]          m_awlen,
  output logic [ID_WIDTH-1:0]           m_awid,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  output logic                          m_wlast,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [LEN_WIDTH-1:0]          m_arlen,
  output logic [ID_WIDTH-1:0]           m_arid,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic                          m_rlast
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH:0]     beat_q, beat_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [IDX_W-1:0]       pick;
  logic                   any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .clock  (clock),
    .rst    (rst),
    .req    (req_valid),
    .update ((state_q == ARB) && any),
    .pick   (pick),
    .any    (any)
  );

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_awlen  = len_q;
  assign m_arlen  = len_q;
  assign m_awid   = ID_WIDTH'(grant_q);
  assign m_arid   = ID_WIDTH'(grant_q);
  assign m_wdata  = cl_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign cl_rdata = m_rdata;
  assign cl_done  = done_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    done_d    = '0;
    req_ready = '0;
    cl_wready = '0;
    cl_rvalid = '0;
    cl_rlast  = 1'b0;
    m_awvalid = 1'b0;
    m_arvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    m_rready  = 1'b0;
    unique case (state_q)
      IDLE: if (|req_valid) state_d = ARB;
      ARB: begin
        // Requests may have been withdrawn since IDLE saw them.
        if (any) begin
          grant_d         = pick;
          addr_d          = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          len_d           = req_len[pick*LEN_WIDTH +: LEN_WIDTH];
          beat_d          = '0;
          req_ready[pick] = 1'b1;
          state_d         = req_wr[pick] ? AW : AR;
        end else begin
          state_d = IDLE;
        end
      end
      AW: begin
        m_awvalid = 1'b1;
        if (m_awready) state_d = WDATA;
      end
      WDATA: begin
        m_wvalid           = cl_wvalid[grant_q];
        cl_wready[grant_q] = m_wready;
        m_wlast            = (beat_q == {1'b0, len_q});
        if (m_wvalid && m_wready) begin
          beat_d = beat_q + (LEN_WIDTH + 1)'(1);
          if (m_wlast) state_d = WRESP;
        end
      end
      WRESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          done_d[grant_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = RDATA;
      end
      RDATA: begin
        cl_rvalid[grant_q] = m_rvalid;
        m_rready           = cl_rready[grant_q];
        cl_rlast           = m_rlast;
        if (m_rvalid && m_rready && m_rlast) begin
          done_d[grant_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
    end
  end

endmodule
